// File: rtl/vram_pkg.sv
// vram_pkg: screen geometry, VRAM widths, writer FSM encoding and rectangle helpers
package vram_pkg;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 360;
    localparam int VRAM_A_WIDTH  = 18;
    localparam int VRAM_D_WIDTH  = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_FIN} state_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] w;
        logic [8:0] h;
    } rect_t;

    function automatic logic geom_ok(input rect_t g);
        return (g.w != '0) && (g.h != '0) &&
               ({1'b0, g.x0} + {1'b0, g.w} <= 11'(SCREEN_WIDTH)) &&
               ({1'b0, g.y0} + {1'b0, g.h} <= 10'(SCREEN_HEIGHT));
    endfunction

    // y0*640 + x0 as two shifted copies of y0 (512 + 128) plus x0
    function automatic logic [VRAM_A_WIDTH-1:0] row_base(input rect_t g);
        return {g.y0, 9'd0} + {2'd0, g.y0, 7'd0} + {8'd0, g.x0};
    endfunction
endpackage

// File: rtl/vram_rect_addr_gen.sv
// vram_rect_addr_gen: row-major rectangle walker (col/row counters, stride add, last flag)
module vram_rect_addr_gen
    import vram_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  rect_t                   i_geom,
    input  logic                    i_rewind,
    input  logic                    i_step,
    output logic [VRAM_A_WIDTH-1:0] o_addr,
    output logic                    o_last
);
    rect_t                   r_geom;
    logic [VRAM_A_WIDTH-1:0] r_base;
    logic [9:0]              r_col;
    logic [8:0]              r_row;
    logic                    w_eol;

    assign w_eol  = r_col == r_geom.w - 10'd1;
    assign o_last = w_eol && (r_row == r_geom.h - 9'd1);
    assign o_addr = r_base + {8'd0, r_col};

    // load/rewind restart at the top-left corner; each step advances one pixel, wrapping rows by the screen stride
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_geom <= '0;
            r_base <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_load) begin
            r_geom <= i_geom;
            r_base <= row_base(i_geom);
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_rewind) begin
            r_base <= row_base(r_geom);
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_step) begin
            r_col  <= w_eol ? '0 : r_col + 10'd1;
            r_row  <= w_eol ? r_row + 9'd1 : r_row;
            r_base <= w_eol ? r_base + VRAM_A_WIDTH'(SCREEN_WIDTH) : r_base;
        end
    end
endmodule

// File: rtl/vram_rect_writer.sv
// vram_rect_writer: streams palette indices row-major into a VRAM rectangle; VRAM_WR_CLEAR_EN adds a pre-fill pass
module vram_rect_writer
    import vram_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [9:0]              i_x0,
    input  logic [8:0]              i_y0,
    input  logic [9:0]              i_w,
    input  logic [8:0]              i_h,
`ifdef VRAM_WR_CLEAR_EN
    input  logic                    i_clr_en,
    input  logic [VRAM_D_WIDTH-1:0] i_clr_val,
`endif
    input  logic                    i_valid,
    input  logic [VRAM_D_WIDTH-1:0] i_data,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic [VRAM_A_WIDTH-1:0] o_addr,
    output logic                    o_write,
    output logic [VRAM_D_WIDTH-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    state_t                  r_state, w_next;
    rect_t                   w_geom;
    logic                    w_ok, w_start, w_load, w_xfer, w_clr_wr, w_clr_go;
    logic                    w_rewind, w_step, w_last;
    logic [VRAM_A_WIDTH-1:0] w_addr, r_addr;
    logic [VRAM_D_WIDTH-1:0] w_clr_val, r_data;
    logic                    r_write, r_rej, r_err;

    assign w_geom   = {i_x0, i_y0, i_w, i_h};
    assign w_ok     = geom_ok(w_geom);
    assign w_start  = (r_state == ST_IDLE) & i_start;
    assign w_load   = w_start & w_ok;
    assign w_xfer   = i_valid & o_ready;
    assign w_clr_wr = r_state == ST_CLEAR;

`ifdef VRAM_WR_CLEAR_EN
    logic [VRAM_D_WIDTH-1:0] r_clr_val;
    assign w_clr_go  = i_clr_en;
    assign w_clr_val = r_clr_val;
    // clear value is captured with the job so the pre-fill is stable for the whole pass
    always_ff @(posedge i_clk) begin
        if (i_rst) r_clr_val <= '0;
        else if (w_load) r_clr_val <= i_clr_val;
    end
`else
    assign w_clr_go  = 1'b0;
    assign w_clr_val = '0;
`endif

    vram_rect_addr_gen u_addr_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_geom  (w_geom),
        .i_rewind(w_rewind),
        .i_step  (w_step),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    // next state and walker control; the clear pass rewinds the walker so streaming restarts at the corner
    always_comb begin
        w_next   = r_state;
        w_rewind = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            ST_IDLE:   w_next = w_load ? (w_clr_go ? ST_CLEAR : ST_STREAM) : ST_IDLE;
            ST_CLEAR: begin
                w_step   = 1'b1;
                w_rewind = w_last;
                w_next   = w_last ? ST_STREAM : ST_CLEAR;
            end
            ST_STREAM: begin
                w_step = w_xfer;
                w_next = (w_xfer & (w_last | i_last)) ? ST_FIN : ST_STREAM;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // state register, registered VRAM port, reject pulse and i_last/geometry mismatch flag of the final pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rej   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_write <= w_clr_wr | w_xfer;
            r_addr  <= (w_clr_wr | w_xfer) ? w_addr : r_addr;
            r_data  <= w_clr_wr ? w_clr_val : w_xfer ? i_data : r_data;
            r_rej   <= w_start & ~w_ok;
            r_err   <= w_xfer ? (w_last ^ i_last) : r_err;
        end
    end

    assign o_ready = r_state == ST_STREAM;
    assign o_busy  = r_state != ST_IDLE;
    assign o_write = r_write;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_done  = (r_state == ST_FIN) | r_rej;
    assign o_err   = ((r_state == ST_FIN) & r_err) | r_rej;
endmodule

// File: tb/tb_vram_rect_writer.sv
// tb_vram_rect_writer: randomized jobs checked every cycle against a pixel-index model of the rectangle writer
module tb_vram_rect_writer;
    import vram_pkg::*;

    typedef enum {P_IDLE, P_CLEAR, P_STREAM, P_FIN} phase_e;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [9:0]  i_x0 = '0;
    logic [8:0]  i_y0 = '0;
    logic [9:0]  i_w = '0;
    logic [8:0]  i_h = '0;
`ifdef VRAM_WR_CLEAR_EN
    logic        i_clr_en = 1'b0;
    logic [5:0]  i_clr_val = '0;
`endif
    logic        i_valid = 1'b0;
    logic [5:0]  i_data = '0;
    logic        i_last = 1'b0;
    logic        o_ready, o_write, o_busy, o_done, o_err;
    logic [17:0] o_addr;
    logic [5:0]  o_data;

    int tests = 0;
    int fails = 0;

    phase_e     m_ph = P_IDLE;
    int         m_k = 0, m_n = 0, m_x0 = 0, m_y0 = 0, m_w = 1;
    logic [5:0] m_clr = '0;
    logic       e_write = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int         e_addr = 0;
    logic [5:0] e_data = '0;
    bit         armed = 1'b0;

    int cap_a[$];
    int cap_d[$];
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0;

    vram_rect_writer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_x0     (i_x0),
        .i_y0     (i_y0),
        .i_w      (i_w),
        .i_h      (i_h),
`ifdef VRAM_WR_CLEAR_EN
        .i_clr_en (i_clr_en),
        .i_clr_val(i_clr_val),
`endif
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_ready  (o_ready),
        .o_addr   (o_addr),
        .o_write  (o_write),
        .o_data   (o_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int pix_addr(input int k);
        return (m_y0 + k / m_w) * SCREEN_WIDTH + m_x0 + k % m_w;
    endfunction

    // reference model: a job is a list of pixel indices k = 0..w*h-1 mapped to (y0+k/w)*640 + x0+k%w
    always @(posedge i_clk) begin
        armed   = 1'b1;
        e_write = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (i_rst) begin
            m_ph   = P_IDLE;
            e_addr = 0;
            e_data = '0;
        end else begin
            case (m_ph)
                P_IDLE: if (i_start) begin
                    if (i_w != 0 && i_h != 0 && int'(i_x0) + int'(i_w) <= SCREEN_WIDTH &&
                        int'(i_y0) + int'(i_h) <= SCREEN_HEIGHT) begin
                        m_x0 = int'(i_x0);
                        m_y0 = int'(i_y0);
                        m_w  = int'(i_w);
                        m_n  = m_w * int'(i_h);
                        m_k  = 0;
`ifdef VRAM_WR_CLEAR_EN
                        m_clr = i_clr_val;
                        m_ph  = i_clr_en ? P_CLEAR : P_STREAM;
`else
                        m_ph  = P_STREAM;
`endif
                    end else begin
                        e_done = 1'b1;
                        e_err  = 1'b1;
                    end
                end
                P_CLEAR: begin
                    e_write = 1'b1;
                    e_addr  = pix_addr(m_k);
                    e_data  = m_clr;
                    m_k++;
                    if (m_k == m_n) begin
                        m_k  = 0;
                        m_ph = P_STREAM;
                    end
                end
                P_STREAM: if (i_valid) begin
                    e_write = 1'b1;
                    e_addr  = pix_addr(m_k);
                    e_data  = i_data;
                    m_k++;
                    if (m_k == m_n || i_last) begin
                        e_done = 1'b1;
                        e_err  = !(m_k == m_n && i_last);
                        m_ph   = P_FIN;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // per-cycle comparison away from the active edge, plus a log of DUT writes and pulses
    always @(negedge i_clk) begin
        if (armed) begin
            chk("write", 32'(o_write), 32'(e_write));
            chk("busy", 32'(o_busy), 32'(m_ph != P_IDLE));
            chk("ready", 32'(o_ready), 32'(m_ph == P_STREAM));
            chk("done", 32'(o_done), 32'(e_done));
            chk("err", 32'(o_err), 32'(e_err));
            if (e_write) begin
                chk("addr", 32'(o_addr), 32'(e_addr));
                chk("data", 32'(o_data), 32'(e_data));
            end
            if (o_write === 1'b1) begin
                cap_a.push_back(int'(o_addr));
                cap_d.push_back(int'(o_data));
            end
            if (o_done === 1'b1) done_cnt++;
            if (o_err === 1'b1) err_cnt++;
            if (o_busy === 1'b1) busy_cnt++;
        end
    end

    task automatic start_job(input int x0, input int y0, input int w, input int h, input bit clr, input int cv);
        @(negedge i_clk);
        i_start = 1'b1;
        i_x0 = 10'(x0);
        i_y0 = 9'(y0);
        i_w  = 10'(w);
        i_h  = 9'(h);
`ifdef VRAM_WR_CLEAR_EN
        i_clr_en  = clr;
        i_clr_val = 6'(cv);
`endif
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random; seq: data = pixel index; stop_at >= 0 halts after that many pixels
    task automatic stream(input int last_idx, input int vmode, input bit seq, input int stop_at, input bit noisy);
        int budget = 5000;
        while (m_ph != P_IDLE && !(stop_at >= 0 && m_k >= stop_at)) begin
            if (m_ph == P_STREAM) begin
                i_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ~i_valid : 1'($urandom_range(0, 1));
                i_data  = seq ? 6'(m_k) : 6'($urandom);
                i_last  = (m_k == last_idx);
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            i_start = noisy && ($urandom_range(0, 7) == 0);
            if (noisy) begin
                i_x0 = 10'($urandom_range(0, 639));
                i_w  = 10'($urandom_range(0, 8));
            end
            @(negedge i_clk);
            budget--;
            if (budget == 0) begin
                chk("job_timeout", 32'(m_ph == P_IDLE), 32'd1);
                break;
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_start = 1'b0;
    endtask

    int b, d0, e0, bz0;
    int t1a[8] = '{0, 1, 2, 3, 640, 641, 642, 643};
    int ca[4] = '{3210, 3211, 3850, 3851};

    initial begin
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_write", 32'(o_write), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        i_rst = 1'b0;

        b = cap_a.size(); d0 = done_cnt; e0 = err_cnt;
        start_job(0, 0, 4, 2, 0, 0);
        stream(7, 0, 1, -1, 0);
        @(negedge i_clk);
        chk("t1_nwr", 32'(cap_a.size() - b), 32'd8);
        if (cap_a.size() - b == 8)
            for (int i = 0; i < 8; i++) begin
                chk("t1_addr", 32'(cap_a[b+i]), 32'(t1a[i]));
                chk("t1_data", 32'(cap_d[b+i]), 32'(i));
            end
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_err", 32'(err_cnt - e0), 32'd0);

        b = cap_a.size(); e0 = err_cnt;
        start_job(636, 359, 4, 1, 0, 0);
        stream(3, 2, 0, -1, 0);
        @(negedge i_clk);
        chk("corner_nwr", 32'(cap_a.size() - b), 32'd4);
        if (cap_a.size() - b == 4)
            for (int i = 0; i < 4; i++) chk("corner_addr", 32'(cap_a[b+i]), 32'(230396 + i));
        chk("corner_err", 32'(err_cnt - e0), 32'd0);

        b = cap_a.size(); d0 = done_cnt; e0 = err_cnt; bz0 = busy_cnt;
        start_job(637, 0, 4, 1, 0, 0);
        repeat (3) @(negedge i_clk);
        chk("rej_done", 32'(done_cnt - d0), 32'd1);
        chk("rej_err", 32'(err_cnt - e0), 32'd1);
        chk("rej_busy", 32'(busy_cnt - bz0), 32'd0);
        chk("rej_nwr", 32'(cap_a.size() - b), 32'd0);

        b = cap_a.size(); e0 = err_cnt;
        start_job(5, 7, 3, 1, 0, 0);
        stream(1, 1, 1, -1, 0);
        @(negedge i_clk);
        chk("early_nwr", 32'(cap_a.size() - b), 32'd2);
        chk("early_err", 32'(err_cnt - e0), 32'd1);

        b = cap_a.size();
        start_job(0, 0, 4, 4, 0, 0);
        stream(15, 0, 1, 5, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mrst_write", 32'(o_write), 32'd0);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        chk("mrst_nwr", 32'(cap_a.size() - b), 32'd5);

`ifdef VRAM_WR_CLEAR_EN
        b = cap_a.size();
        start_job(10, 5, 2, 2, 1, 63);
        stream(3, 0, 1, -1, 0);
        @(negedge i_clk);
        chk("clr_nwr", 32'(cap_a.size() - b), 32'd8);
        if (cap_a.size() - b == 8)
            for (int i = 0; i < 4; i++) begin
                chk("clr_addr", 32'(cap_a[b+i]), 32'(ca[i]));
                chk("clr_data", 32'(cap_d[b+i]), 32'd63);
                chk("ovr_addr", 32'(cap_a[b+4+i]), 32'(ca[i]));
                chk("ovr_data", 32'(cap_d[b+4+i]), 32'(i));
            end
`endif

        start_job(0, 0, 640, 1, 0, 0);
        stream(639, 2, 0, -1, 1);
        start_job(639, 0, 1, 360, 0, 0);
        stream(359, 0, 0, -1, 0);
        start_job(0, 0, 0, 1, 0, 0);
        start_job(0, 300, 1, 61, 0, 0);

        for (int j = 0; j < 30; j++) begin
            int w, h, x0, y0, n, li, r;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 5);
            n = w * h;
            y0 = $urandom_range(0, 360 - h);
            x0 = ($urandom_range(0, 4) == 0) ? 640 - w + $urandom_range(1, w) : $urandom_range(0, 640 - w);
            r = $urandom_range(0, 5);
            li = (r == 0) ? n : (r == 1) ? $urandom_range(0, n - 1) : n - 1;
            start_job(x0, y0, w, h, 1'($urandom_range(0, 1)), $urandom_range(0, 63));
            stream(li, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, 1);
            repeat (2) @(negedge i_clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
